// File: rtl/divisor_palabra_16_pkg.sv
// Shared definitions for the 32->16 word splitter: state encodings and default widths.
package divisor_palabra_16_pkg;

   localparam int ANCHO_MEDIA_DEF   = 16;
   localparam int ANCHO_PALABRA_DEF = 2 * ANCHO_MEDIA_DEF;

   // Encoding 2'd3 is unused and falls back to VACIO.
   typedef enum logic [1:0] {
      VACIO   = 2'd0,
      PRIMERA = 2'd1,
      SEGUNDA = 2'd2
   } estado_t;

endpackage

// File: rtl/divisor_palabra_16.sv
// Splits a 2*ANCHO_MEDIA-bit word into two half-word beats on a valid/ready bus.
// Optional feature (macro SALTAR_MEDIA_CERO_EN): a word whose second-sent half is
// all zeros emits only its first beat, marked as the last one.
//
// state   | meaning
// --------+-----------------------------------------------------------
// VACIO   | no word buffered, ready to accept
// PRIMERA | first half on the bus, second half held in r_media_pend
// SEGUNDA | last beat on the bus; may accept the next word on transfer
module divisor_palabra_16
   import divisor_palabra_16_pkg::*;
#(
   parameter int ANCHO_MEDIA  = ANCHO_MEDIA_DEF,
   parameter bit ALTA_PRIMERO = 1'b1
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [2*ANCHO_MEDIA-1:0] i_entrada,
   input  logic                     i_entrada_valida,
   output logic                     o_entrada_lista,
   output logic [ANCHO_MEDIA-1:0]   o_salida,
   output logic                     o_salida_valida,
   input  logic                     i_salida_lista,
   output logic                     o_salida_alta,
   output logic                     o_ultima
);

   estado_t                r_estado;
   logic [ANCHO_MEDIA-1:0] r_media_pend;

   logic [ANCHO_MEDIA-1:0] w_alta_entrada;
   logic [ANCHO_MEDIA-1:0] w_baja_entrada;
   logic [ANCHO_MEDIA-1:0] w_primera_entrada;
   logic [ANCHO_MEDIA-1:0] w_segunda_entrada;
   logic                   w_acepta;
   logic                   w_transfer;
   logic                   w_salta;

   assign w_alta_entrada    = i_entrada[2*ANCHO_MEDIA-1:ANCHO_MEDIA];
   assign w_baja_entrada    = i_entrada[ANCHO_MEDIA-1:0];
   assign w_primera_entrada = ALTA_PRIMERO ? w_alta_entrada : w_baja_entrada;
   assign w_segunda_entrada = ALTA_PRIMERO ? w_baja_entrada : w_alta_entrada;

`ifdef SALTAR_MEDIA_CERO_EN
   assign w_salta = (w_segunda_entrada == '0);
`else
   assign w_salta = 1'b0;
`endif

   // Ready is only raised when the current word is finished (or about to be).
   always_comb begin
      o_entrada_lista = 1'b0;
      if (!i_reset) begin
         case (r_estado)
            VACIO:   o_entrada_lista = 1'b1;
            SEGUNDA: o_entrada_lista = i_salida_lista;
            default: o_entrada_lista = 1'b0;
         endcase
      end
   end

   assign w_acepta   = i_entrada_valida && o_entrada_lista;
   assign w_transfer = o_salida_valida && i_salida_lista;

   // FSM with registered beat outputs; a skipped word goes straight to SEGUNDA
   // carrying its first half, so back-to-back acceptance works unchanged.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_estado        <= VACIO;
         r_media_pend    <= '0;
         o_salida        <= '0;
         o_salida_valida <= 1'b0;
         o_salida_alta   <= 1'b0;
         o_ultima        <= 1'b0;
      end else begin
         case (r_estado)
            VACIO, SEGUNDA: begin
               if (w_acepta) begin
                  r_estado        <= w_salta ? SEGUNDA : PRIMERA;
                  r_media_pend    <= w_segunda_entrada;
                  o_salida        <= w_primera_entrada;
                  o_salida_valida <= 1'b1;
                  o_salida_alta   <= ALTA_PRIMERO;
                  o_ultima        <= w_salta;
               end else if (r_estado == SEGUNDA && w_transfer) begin
                  r_estado        <= VACIO;
                  o_salida        <= '0;
                  o_salida_valida <= 1'b0;
                  o_salida_alta   <= 1'b0;
                  o_ultima        <= 1'b0;
               end
            end
            PRIMERA: begin
               if (w_transfer) begin
                  r_estado      <= SEGUNDA;
                  o_salida      <= r_media_pend;
                  o_salida_alta <= !ALTA_PRIMERO;
                  o_ultima      <= 1'b1;
               end
            end
            default: begin
               r_estado        <= VACIO;
               r_media_pend    <= '0;
               o_salida        <= '0;
               o_salida_valida <= 1'b0;
               o_salida_alta   <= 1'b0;
               o_ultima        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_palabra_16.sv
// Directed bench for divisor_palabra_16: one instance high-half-first, one low-half-first.
module tb_divisor_palabra_16;

   logic        clk;
   logic        reset;
   logic [31:0] entrada;
   logic        entrada_valida;
   logic        salida_lista;

   logic        a_elista, a_valida, a_alta, a_ultima;
   logic [15:0] a_salida;
   logic        b_elista, b_valida, b_alta, b_ultima;
   logic [15:0] b_salida;

   int n_checks = 0;
   int n_fallos = 0;

   divisor_palabra_16 #(.ANCHO_MEDIA(16), .ALTA_PRIMERO(1'b1)) u_dut_a (
      .i_clk(clk), .i_reset(reset), .i_entrada(entrada),
      .i_entrada_valida(entrada_valida), .o_entrada_lista(a_elista),
      .o_salida(a_salida), .o_salida_valida(a_valida),
      .i_salida_lista(salida_lista), .o_salida_alta(a_alta), .o_ultima(a_ultima)
   );

   divisor_palabra_16 #(.ANCHO_MEDIA(16), .ALTA_PRIMERO(1'b0)) u_dut_b (
      .i_clk(clk), .i_reset(reset), .i_entrada(entrada),
      .i_entrada_valida(entrada_valida), .o_entrada_lista(b_elista),
      .o_salida(b_salida), .o_salida_valida(b_valida),
      .i_salida_lista(salida_lista), .o_salida_alta(b_alta), .o_ultima(b_ultima)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_checks++;
      if (obs !== esp) begin
         n_fallos++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
      end
   endtask

   task automatic sig_ciclo();
      @(posedge clk);
      #1;
   endtask

   // Checks instance A at the next falling edge.
   task automatic ver_a(input string tag, input logic val, input logic [15:0] sal,
                        input logic alta, input logic ult, input logic elista);
      @(negedge clk);
      chequear({tag, ".valida"}, 32'(a_valida), 32'(val));
      if (val) begin
         chequear({tag, ".salida"}, 32'(a_salida), 32'(sal));
         chequear({tag, ".alta"},   32'(a_alta),   32'(alta));
         chequear({tag, ".ultima"}, 32'(a_ultima), 32'(ult));
      end
      chequear({tag, ".elista"}, 32'(a_elista), 32'(elista));
   endtask

   task automatic ver_b(input string tag, input logic val, input logic [15:0] sal,
                        input logic alta, input logic ult);
      @(negedge clk);
      chequear({tag, ".valida"}, 32'(b_valida), 32'(val));
      chequear({tag, ".salida"}, 32'(b_salida), 32'(sal));
      chequear({tag, ".alta"},   32'(b_alta),   32'(alta));
      chequear({tag, ".ultima"}, 32'(b_ultima), 32'(ult));
   endtask

   task automatic hacer_reset();
      reset = 1'b1;
      entrada_valida = 1'b0;
      salida_lista = 1'b0;
      sig_ciclo();
      sig_ciclo();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      entrada = '0;
      entrada_valida = 1'b0;
      salida_lista = 1'b0;

      // Reset state
      sig_ciclo();
      @(negedge clk);
      chequear("rst.valida", 32'(a_valida), 32'd0);
      chequear("rst.salida", 32'(a_salida), 32'd0);
      chequear("rst.alta",   32'(a_alta),   32'd0);
      chequear("rst.ultima", 32'(a_ultima), 32'd0);
      chequear("rst.elista", 32'(a_elista), 32'd0);
      sig_ciclo();
      reset = 1'b0;

      // Basic split, high half first
      entrada = 32'h1234ABCD; entrada_valida = 1'b1; salida_lista = 1'b1;
      ver_a("idle", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      sig_ciclo();
      entrada_valida = 1'b0;
      ver_a("w1.b0", 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
      sig_ciclo();
      ver_a("w1.b1", 1'b1, 16'hABCD, 1'b0, 1'b1, 1'b1);
      sig_ciclo();
      ver_a("w1.fin", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

      // Back-to-back words, entrada ignored during PRIMERA
      entrada = 32'h00010002; entrada_valida = 1'b1;
      sig_ciclo();
      entrada = 32'h00030004;
      ver_a("bb.b0", 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
      sig_ciclo();
      ver_a("bb.b1", 1'b1, 16'h0002, 1'b0, 1'b1, 1'b1);
      sig_ciclo();
      entrada_valida = 1'b0;
      ver_a("bb.b2", 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
      sig_ciclo();
      ver_a("bb.b3", 1'b1, 16'h0004, 1'b0, 1'b1, 1'b1);
      sig_ciclo();
      ver_a("bb.fin", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

      // Stall on first beat, then stall on last beat with a pending input word
      entrada = 32'h1234ABCD; entrada_valida = 1'b1; salida_lista = 1'b0;
      sig_ciclo();
      entrada = 32'h55556666;
      for (int i = 0; i < 3; i++) begin
         ver_a("stall.b0", 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
         sig_ciclo();
      end
      salida_lista = 1'b1;
      ver_a("stall.b0go", 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
      sig_ciclo();
      salida_lista = 1'b0;
      ver_a("stall.b1", 1'b1, 16'hABCD, 1'b0, 1'b1, 1'b0);
      sig_ciclo();
      entrada_valida = 1'b0; salida_lista = 1'b1;
      ver_a("stall.b1go", 1'b1, 16'hABCD, 1'b0, 1'b1, 1'b1);
      sig_ciclo();
      ver_a("stall.fin", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

      // Reset during the last beat discards the word
      entrada = 32'hCAFEBEEF; entrada_valida = 1'b1;
      sig_ciclo();
      entrada_valida = 1'b0;
      ver_a("rs.b0", 1'b1, 16'hCAFE, 1'b1, 1'b0, 1'b0);
      sig_ciclo();
      ver_a("rs.b1", 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1);
      reset = 1'b1;
      sig_ciclo();
      @(negedge clk);
      chequear("rs.valida", 32'(a_valida), 32'd0);
      chequear("rs.salida", 32'(a_salida), 32'd0);
      chequear("rs.elista", 32'(a_elista), 32'd0);
      reset = 1'b0;
      sig_ciclo();
      ver_a("rs.after", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

      // Zero second half
      entrada = 32'h3C000000; entrada_valida = 1'b1;
      sig_ciclo();
      entrada_valida = 1'b0;
`ifdef SALTAR_MEDIA_CERO_EN
      ver_a("z.b0", 1'b1, 16'h3C00, 1'b1, 1'b1, 1'b1);
      sig_ciclo();
      ver_a("z.fin", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
`else
      ver_a("z.b0", 1'b1, 16'h3C00, 1'b1, 1'b0, 1'b0);
      sig_ciclo();
      ver_a("z.b1", 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
      sig_ciclo();
      ver_a("z.fin", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
`endif

      // Low half first on the second instance
      hacer_reset();
      entrada = 32'hDEAD0001; entrada_valida = 1'b1; salida_lista = 1'b1;
      sig_ciclo();
      entrada_valida = 1'b0;
      ver_b("lo.b0", 1'b1, 16'h0001, 1'b0, 1'b0);
      sig_ciclo();
      ver_b("lo.b1", 1'b1, 16'hDEAD, 1'b1, 1'b1);
      sig_ciclo();
      ver_b("lo.fin", 1'b0, 16'h0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fallos);
      $finish;
   end

endmodule
